vector_sum_stream: RTL



---
 rtl/vector_sum_pkg.sv | 15 +
 rtl/vector_popcount.sv | 19 +
 rtl/vector_sum_stream.sv | 132 +++++++++++++
 3 files changed

// File: rtl/vector_sum_pkg.sv
// Shared types and helpers for the vector bit-sum stream blocks.
package vector_sum_pkg;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // Width needed to hold a count of 0..data_w inclusive.
  function automatic int cnt_w(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/vector_popcount.sv
// Combinational population count of a DATA_W-bit word.
module vector_popcount
  import vector_sum_pkg::*;
#(
  parameter int DATA_W = 10,
  parameter int CNT_W  = cnt_w(DATA_W)
) (
  input  logic [DATA_W-1:0] data_i,
  output logic [CNT_W-1:0]  count_o
);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < DATA_W; i++) begin
      count_o = count_o + CNT_W'(data_i[i]);
    end
  end

endmodule

// File: rtl/vector_sum_stream.sv
// Streaming per-frame bit-count accumulator with valid/ready in and out.
//  state | meaning
//  ACCUM | accepting words, accumulating counts
//  DRAIN | last word accepted, waiting for it to reach the accumulator
//  HOLD  | frame result presented, waiting for consumer handshake
module vector_sum_stream
  import vector_sum_pkg::*;
#(
  parameter  int DATA_W = 10,
  parameter  int ACC_W  = 16,
  localparam int CNT_W  = cnt_w(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_zeros,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [ACC_W-1:0]  out_words,
  output logic              out_sat
);

  state_e             state_q, state_d;
  logic               in_ready_q, in_ready_d;
  logic               s1_valid_q, s1_last_q;
  logic [CNT_W-1:0]   s1_cnt_q, cnt_d, pop;
  logic [ACC_W-1:0]   acc_q, words_q, acc_nxt, words_nxt;
  logic               sat_q, sat_nxt;
  logic [ACC_W:0]     sum_ext, words_ext;
  logic               out_valid_q, out_sat_q;
  logic [ACC_W-1:0]   out_sum_q, out_words_q;
  logic               accept, load_out, clear;

  vector_popcount #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_popcount (
    .data_i  (in_data),
    .count_o (pop)
  );

  assign accept = in_valid && in_ready_q;
  assign cnt_d  = in_zeros ? (CNT_W'(DATA_W) - pop) : pop;

  // Carry out of the widened add flags saturation.
  assign sum_ext   = {1'b0, acc_q} + (ACC_W + 1)'(s1_cnt_q);
  assign words_ext = {1'b0, words_q} + (ACC_W + 1)'(1);
  assign acc_nxt   = sum_ext[ACC_W]   ? '1 : sum_ext[ACC_W-1:0];
  assign words_nxt = words_ext[ACC_W] ? '1 : words_ext[ACC_W-1:0];
  assign sat_nxt   = sat_q | sum_ext[ACC_W] | words_ext[ACC_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ACCUM;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (accept && in_last)        state_d = DRAIN;
      DRAIN:   if (s1_valid_q && s1_last_q)  state_d = HOLD;
      HOLD:    if (out_valid_q && out_ready) state_d = ACCUM;
      default:                               state_d = ACCUM;
    endcase
  end

  always_comb begin
    in_ready_d = (state_d == ACCUM);
    load_out   = (state_q == DRAIN) && s1_valid_q && s1_last_q;
    clear      = (state_q == HOLD) && out_valid_q && out_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_cnt_q   <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_last_q <= in_last;
        s1_cnt_q  <= cnt_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      words_q <= '0;
      sat_q   <= 1'b0;
    end else if (clear) begin
      acc_q   <= '0;
      words_q <= '0;
      sat_q   <= 1'b0;
    end else if (s1_valid_q) begin
      acc_q   <= acc_nxt;
      words_q <= words_nxt;
      sat_q   <= sat_nxt;
    end
  end

  // Output registers take the post-update totals so the last word is included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_words_q <= '0;
      out_sat_q   <= 1'b0;
    end else if (load_out) begin
      out_valid_q <= 1'b1;
      out_sum_q   <= acc_nxt;
      out_words_q <= words_nxt;
      out_sat_q   <= sat_nxt;
    end else if (clear) begin
      out_valid_q <= 1'b0;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_words = out_words_q;
  assign out_sat   = out_sat_q;

endmodule
